// File: rtl/vga_frame_reader.sv
// ---------------------------------------------------------------------------
// vga_frame_reader
//
// Reads a FB_WIDTH-wide RGB565 frame buffer and shows it 2x upscaled on a
// VGA timing raster (640x480@60 with the default parameters). A pixel tick
// is derived from the system clock by dividing it by CLK_DIV.
//
// Pipeline, one stage per pixel tick:
//   stage A (on the tick edge): snapshot of the current (h,v) raster
//            position -> RAM read request (addr_out/regread) plus sync and
//            first-pixel flags for that position.
//   stage B (on the next tick edge): RAM data (valid one clk after the
//            request) and the delayed flags become the VGA outputs, so RGB
//            and syncs stay aligned.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   addr_out    frame-buffer read address
//   regread     frame-buffer read enable
//   ram_data    frame-buffer read data (RGB565), one clk after the request
//   vga_hsync   horizontal sync, active-low
//   vga_vsync   vertical sync, active-low
//   vga_r/g/b   colour components, zero during blanking
//   visible     high while the displayed pixel is in the active area
//   frame_start one-clk pulse when pixel (0,0) is put on the outputs
// ---------------------------------------------------------------------------
module vga_frame_reader #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int FB_WIDTH  = 320,
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] addr_out,
    output logic              regread,
    input  logic [DATA_W-1:0] ram_data,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic [4:0]        vga_r,
    output logic [5:0]        vga_g,
    output logic [4:0]        vga_b,
    output logic              visible,
    output logic              frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]    H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]    H_ACT    = H_W'(H_VISIBLE);
    localparam logic [H_W-1:0]    HS_BEGIN = H_W'(H_VISIBLE + H_FRONT);
    localparam logic [H_W-1:0]    HS_END   = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0]    V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]    V_ACT    = V_W'(V_VISIBLE);
    localparam logic [V_W-1:0]    VS_BEGIN = V_W'(V_VISIBLE + V_FRONT);
    localparam logic [V_W-1:0]    VS_END   = V_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [ADDR_W-1:0] FB_STEP  = ADDR_W'(FB_WIDTH);

    // The RAM answers one clk after the request; with a single-clk tick the
    // data would arrive after stage B has already sampled it.
    if (CLK_DIV < 2) begin : g_bad_div
        $error("vga_frame_reader: CLK_DIV must be at least 2");
    end

    // Raster state
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [H_W-1:0]    h_cnt_q, h_cnt_d;
    logic [V_W-1:0]    v_cnt_q, v_cnt_d;
    // (v_cnt>>1)*FB_WIDTH kept as a running sum instead of a multiplier
    logic [ADDR_W-1:0] row_base_q, row_base_d;

    // Stage A
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              regread_q, regread_d;
    logic              hs_a_q, hs_a_d;
    logic              vs_a_q, vs_a_d;
    logic              first_a_q, first_a_d;

    // Stage B
    logic [DATA_W-1:0] rgb_q, rgb_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              visible_q, visible_d;
    logic              frame_start_q, frame_start_d;

    logic tick;
    logic act;

    assign tick = (div_cnt_q == DIV_LAST);
    assign act  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

    always_comb begin
        div_cnt_d     = tick ? '0 : div_cnt_q + 1'b1;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        row_base_d    = row_base_q;

        addr_d        = addr_q;
        regread_d     = regread_q;
        hs_a_d        = hs_a_q;
        vs_a_d        = vs_a_q;
        first_a_d     = first_a_q;

        rgb_d         = rgb_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        visible_d     = visible_q;
        frame_start_d = 1'b0;

        if (tick) begin
            // Raster counters
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d    = '0;
                    row_base_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                    // leaving an odd line means the next source row begins
                    if (v_cnt_q[0]) begin
                        row_base_d = row_base_q + FB_STEP;
                    end
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end

            // Stage A: request the pixel for the current position
            regread_d = act;
            if (act) begin
                addr_d = row_base_q + ADDR_W'(h_cnt_q >> 1);
            end
            hs_a_d    = (h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END);
            vs_a_d    = (v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END);
            first_a_d = (h_cnt_q == '0) && (v_cnt_q == '0);

            // Stage B: present the pixel requested on the previous tick;
            // regread_q doubles as that pixel's active flag.
            rgb_d         = regread_q ? ram_data : '0;
            hsync_d       = ~hs_a_q;
            vsync_d       = ~vs_a_q;
            visible_d     = regread_q;
            frame_start_d = first_a_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            row_base_q    <= '0;
            addr_q        <= '0;
            regread_q     <= 1'b0;
            hs_a_q        <= 1'b0;
            vs_a_q        <= 1'b0;
            first_a_q     <= 1'b0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            visible_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            row_base_q    <= row_base_d;
            addr_q        <= addr_d;
            regread_q     <= regread_d;
            hs_a_q        <= hs_a_d;
            vs_a_q        <= vs_a_d;
            first_a_q     <= first_a_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            visible_q     <= visible_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign addr_out    = addr_q;
    assign regread     = regread_q;
    assign vga_r       = rgb_q[15:11];
    assign vga_g       = rgb_q[10:5];
    assign vga_b       = rgb_q[4:0];
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign visible     = visible_q;
    assign frame_start = frame_start_q;

endmodule
